// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS-subset core: one ALU, one unified memory port with a ready
// handshake, and an FSM that spends 3-5 states per instruction.
module multicycle_mips_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       retired,
  output logic              halted
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t      state, state_nx;
  logic [31:0] ir, a, b, mdr, alu_out;
  logic [31:0] rf [32];
  logic        active;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx, pc_ext, alu_res, jump_target;
  logic        funct_ok;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign funct       = ir[5:0];
  assign imm_sx      = {{16{ir[15]}}, ir[15:0]};
  assign pc_ext      = 32'(pc);
  assign jump_target = {pc_ext[31:28], ir[25:0], 2'b00};
  assign mem_wdata   = b;

  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_res = a + b;
      FN_SUB:  alu_res = a - b;
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
      default: funct_ok = 1'b0;
    endcase
  end

  // FETCH stays silent for the first cycle after reset release via 'active'
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = alu_out[ADDR_W-1:0];
    halted   = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = active;
        mem_addr = pc;
        if (active && mem_ready) state_nx = DECODE;
      end
      DECODE: begin
        case (op)
          OP_RTYPE:     state_nx = funct_ok ? EXEC : HALT;
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_ADDI:      state_nx = ADDIEX;
          OP_BEQ:       state_nx = BRANCH;
          OP_J:         state_nx = JUMP;
          default:      state_nx = HALT;
        endcase
      end
      MEMADR: state_nx = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        mem_req = 1'b1;
        if (mem_ready) state_nx = MEMWB;
      end
      MEMWB: state_nx = FETCH;
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) state_nx = FETCH;
      end
      EXEC:   state_nx = ALUWB;
      ALUWB:  state_nx = FETCH;
      ADDIEX: state_nx = ADDIWB;
      ADDIWB: state_nx = FETCH;
      BRANCH: state_nx = FETCH;
      JUMP:   state_nx = FETCH;
      HALT:   halted   = 1'b1;
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  // Datapath registers; each final state bumps 'retired' as it commits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC[ADDR_W-1:0];
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      alu_out <= '0;
      retired <= '0;
      active  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      active <= 1'b1;
      case (state)
        FETCH: if (active && mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(4);
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc_ext + (imm_sx << 2);
        end
        MEMADR, ADDIEX: alu_out <= a + imm_sx;
        MEMRD: if (mem_ready) mdr <= mem_rdata;
        MEMWB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          retired <= retired + 32'd1;
        end
        MEMWR: if (mem_ready) retired <= retired + 32'd1;
        EXEC: alu_out <= alu_res;
        ALUWB: begin
          if (rd != 5'd0) rf[rd] <= alu_out;
          retired <= retired + 32'd1;
        end
        ADDIWB: begin
          if (rt != 5'd0) rf[rt] <= alu_out;
          retired <= retired + 32'd1;
        end
        BRANCH: begin
          if (a == b) pc <= alu_out[ADDR_W-1:0];
          retired <= retired + 32'd1;
        end
        JUMP: begin
          pc      <= jump_target[ADDR_W-1:0];
          retired <= retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Scoreboard bench for multicycle_mips_core: expected bus transactions are
// queued by the stimulus and popped by a monitor as the core completes them.
module tb_multicycle_mips_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, retired;
  logic        mem_req2, mem_we2, halted2;
  logic [15:0] mem_addr2, pc2;
  logic [31:0] mem_wdata2, mem_rdata2, retired2;

  logic [31:0] mem [256];
  int          stall_limit, stall_used;
  logic [31:0] stall_addr;
  logic        stall_we;
  int          vectors, miscompares;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t exp_q[$];

  multicycle_mips_core #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .retired(retired), .halted(halted)
  );

  multicycle_mips_core #(.ADDR_W(16), .RESET_PC(32'h0)) dut16 (
    .clk(clk), .rst_n(rst2_n), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .mem_ready(1'b1), .pc(pc2), .retired(retired2), .halted(halted2)
  );

  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_rdata2 = mem[mem_addr2[9:2]];
  assign mem_ready  = !(stall_used < stall_limit && mem_addr == stall_addr && mem_we == stall_we);

  always @(posedge clk) begin
    if (!rst_n)                    stall_used <= 0;
    else if (mem_req && !mem_ready) stall_used <= stall_used + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic        hold_valid = 1'b0;
  logic        hold_we;
  logic [31:0] hold_addr, hold_data;

  // Monitor: checks bus stability during waits, scores completed transfers
  always @(negedge clk) begin
    txn_t e;
    if (hold_valid && mem_req) begin
      check_output("hold-addr", mem_addr, hold_addr);
      check_output("hold-we", {31'b0, mem_we}, {31'b0, hold_we});
      check_output("hold-wdata", mem_wdata, hold_data);
    end
    hold_valid <= mem_req && !mem_ready;
    hold_addr  <= mem_addr;
    hold_we    <= mem_we;
    hold_data  <= mem_wdata;
    if (rst_n && mem_req && mem_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL txn-unexpected: got we=%0b addr=0x%08h, expected none", mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        check_output("txn-we", {31'b0, mem_we}, {31'b0, e.we});
        check_output("txn-addr", mem_addr, e.addr);
        if (e.we) check_output("txn-wdata", mem_wdata, e.data);
      end
      if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
    end
  end

  task automatic reset_core();
    @(negedge clk);
    rst_n = 1'b0;
    rst2_n = 1'b0;
    stall_limit = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[9:2]] = word;
  endtask

  task automatic expect_txn(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back('{we: we, addr: addr, data: data});
  endtask

  task automatic release_core();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_output("req-idle", {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    #1 check_output("req-first", {31'b0, mem_req}, 32'h1);
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check_output("halt-reached", {31'b0, halted}, 32'h1);
  endtask

  task automatic drain();
    check_output("txn-drain", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    stall_limit = 0;
    stall_addr = '0;
    stall_we = 1'b0;

    // Reset state and illegal all-zero word
    reset_core();
    #1;
    check_output("rst-pc", pc, 32'h40);
    check_output("rst-retired", retired, 32'h0);
    check_output("rst-halted", {31'b0, halted}, 32'h0);
    check_output("rst-req", {31'b0, mem_req}, 32'h0);
    expect_txn(1'b0, 32'h40, 32'h0);
    release_core();
    check_output("first-addr", mem_addr, 32'h40);
    run_to_halt(20);
    check_output("t1-retired", retired, 32'h0);
    check_output("t1-pc", pc, 32'h44);
    check_output("t1-req", {31'b0, mem_req}, 32'h0);
    drain();

    // addi/addi/add/sw/lw then store the loaded value
    reset_core();
    apply_stimulus(32'h40, 32'h20010005);
    apply_stimulus(32'h44, 32'h20020007);
    apply_stimulus(32'h48, 32'h00221820);
    apply_stimulus(32'h4C, 32'hAC030010);
    apply_stimulus(32'h50, 32'h8C040010);
    apply_stimulus(32'h54, 32'hAC040014);
    expect_txn(1'b0, 32'h40, 0); expect_txn(1'b0, 32'h44, 0);
    expect_txn(1'b0, 32'h48, 0); expect_txn(1'b0, 32'h4C, 0);
    expect_txn(1'b1, 32'h10, 32'd12);
    expect_txn(1'b0, 32'h50, 0); expect_txn(1'b0, 32'h10, 0);
    expect_txn(1'b0, 32'h54, 0); expect_txn(1'b1, 32'h14, 32'd12);
    expect_txn(1'b0, 32'h58, 0);
    release_core();
    repeat (20) @(posedge clk);
    #1 check_output("t2-retired-20", retired, 32'd4);
    @(posedge clk);
    #1 check_output("t2-retired-21", retired, 32'd5);
    run_to_halt(60);
    check_output("t2-mem10", mem[4], 32'd12);
    check_output("t2-mem14", mem[5], 32'd12);
    check_output("t2-retired", retired, 32'd6);
    check_output("t2-pc", pc, 32'h5C);
    drain();

    // beq taken, addi, beq not taken, illegal opcode
    reset_core();
    apply_stimulus(32'h40, 32'h10000002);
    apply_stimulus(32'h44, 32'h20090001);
    apply_stimulus(32'h48, 32'h20090002);
    apply_stimulus(32'h4C, 32'h20010001);
    apply_stimulus(32'h50, 32'h10200005);
    apply_stimulus(32'h54, 32'hFFFFFFFF);
    expect_txn(1'b0, 32'h40, 0); expect_txn(1'b0, 32'h4C, 0);
    expect_txn(1'b0, 32'h50, 0); expect_txn(1'b0, 32'h54, 0);
    release_core();
    repeat (3) @(posedge clk);
    #1 check_output("t3-beq-retired", retired, 32'd1);
    check_output("t3-beq-target", mem_addr, 32'h4C);
    run_to_halt(40);
    check_output("t3-retired", retired, 32'd3);
    check_output("t3-pc", pc, 32'h58);
    drain();

    // slt/sub/and/or, signed compare, $0 write dropped
    reset_core();
    apply_stimulus(32'h40, 32'h2001FFFF);
    apply_stimulus(32'h44, 32'h20020001);
    apply_stimulus(32'h48, 32'h0022182A);
    apply_stimulus(32'h4C, 32'h00022022);
    apply_stimulus(32'h50, 32'h00222824);
    apply_stimulus(32'h54, 32'h00443025);
    apply_stimulus(32'h58, 32'h0041382A);
    apply_stimulus(32'h5C, 32'h20000009);
    apply_stimulus(32'h60, 32'hAC030020);
    apply_stimulus(32'h64, 32'hAC040024);
    apply_stimulus(32'h68, 32'hAC050028);
    apply_stimulus(32'h6C, 32'hAC06002C);
    apply_stimulus(32'h70, 32'hAC070030);
    apply_stimulus(32'h74, 32'hAC000034);
    apply_stimulus(32'h30, 32'hA5A5A5A5);
    apply_stimulus(32'h34, 32'hA5A5A5A5);
    for (int i = 0; i < 8; i++) expect_txn(1'b0, 32'h40 + 32'(4 * i), 0);
    expect_txn(1'b0, 32'h60, 0); expect_txn(1'b1, 32'h20, 32'h1);
    expect_txn(1'b0, 32'h64, 0); expect_txn(1'b1, 32'h24, 32'hFFFFFFFF);
    expect_txn(1'b0, 32'h68, 0); expect_txn(1'b1, 32'h28, 32'h1);
    expect_txn(1'b0, 32'h6C, 0); expect_txn(1'b1, 32'h2C, 32'hFFFFFFFF);
    expect_txn(1'b0, 32'h70, 0); expect_txn(1'b1, 32'h30, 32'h0);
    expect_txn(1'b0, 32'h74, 0); expect_txn(1'b1, 32'h34, 32'h0);
    expect_txn(1'b0, 32'h78, 0);
    release_core();
    run_to_halt(100);
    check_output("t4-slt", mem[8], 32'h1);
    check_output("t4-sub", mem[9], 32'hFFFFFFFF);
    check_output("t4-slt-rev", mem[12], 32'h0);
    check_output("t4-r0", mem[13], 32'h0);
    check_output("t4-retired", retired, 32'd14);
    check_output("t4-pc", pc, 32'h7C);
    drain();

    // lw with three wait cycles on the data read
    reset_core();
    stall_addr = 32'h18;
    stall_we = 1'b0;
    stall_limit = 3;
    apply_stimulus(32'h18, 32'hDEADBEEF);
    apply_stimulus(32'h40, 32'h8C050018);
    apply_stimulus(32'h44, 32'hAC05001C);
    expect_txn(1'b0, 32'h40, 0); expect_txn(1'b0, 32'h18, 0);
    expect_txn(1'b0, 32'h44, 0); expect_txn(1'b1, 32'h1C, 32'hDEADBEEF);
    expect_txn(1'b0, 32'h48, 0);
    release_core();
    repeat (7) @(posedge clk);
    #1 check_output("t5-retired-7", retired, 32'd0);
    @(posedge clk);
    #1 check_output("t5-retired-8", retired, 32'd1);
    run_to_halt(40);
    check_output("t5-store", mem[7], 32'hDEADBEEF);
    check_output("t5-retired", retired, 32'd2);
    drain();

    // Reset while a store waits for ready
    reset_core();
    stall_addr = 32'h38;
    stall_we = 1'b1;
    stall_limit = 1000;
    apply_stimulus(32'h38, 32'h12345678);
    apply_stimulus(32'h40, 32'h20010055);
    apply_stimulus(32'h44, 32'hAC010038);
    expect_txn(1'b0, 32'h40, 0); expect_txn(1'b0, 32'h44, 0);
    release_core();
    repeat (10) @(posedge clk);
    #1 check_output("t6-wait-we", {31'b0, mem_req & mem_we}, 32'h1);
    check_output("t6-wait-addr", mem_addr, 32'h38);
    check_output("t6-pre-retired", retired, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_output("t6-req", {31'b0, mem_req}, 32'h0);
    check_output("t6-pc", pc, 32'h40);
    check_output("t6-retired", retired, 32'h0);
    check_output("t6-nowrite", mem[14], 32'h12345678);
    drain();

    // j on a 16-bit address core truncates the target
    reset_core();
    apply_stimulus(32'h0, 32'h08123456);
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk);
    #1 check_output("t7-first-addr", {16'h0, mem_addr2}, 32'h0);
    repeat (3) @(posedge clk);
    #1 check_output("t7-target", {16'h0, mem_addr2}, 32'hD158);
    check_output("t7-retired-j", retired2, 32'd1);
    for (int n = 0; n < 20 && !halted2; n++) begin
      @(posedge clk);
      #1;
    end
    check_output("t7-halted", {31'b0, halted2}, 32'h1);
    check_output("t7-pc", {16'h0, pc2}, 32'hD15C);
    check_output("t7-retired", retired2, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_mips_core.md
# multicycle_mips_core

Multicycle MIPS-subset processor core and the parametrised successor to the single-cycle datapath. One ALU, one external unified memory port with a ready handshake, and an FSM that runs each instruction over 3–5 states. It adds reset, branch-target arithmetic, jumps, memory wait states, a halt on illegal opcodes and a retired-instruction counter. It sits between the lab memory model or RAM wrapper and the top-level test harness.

## Interface
- `ADDR_W`, 32: byte-address width of PC and `mem_addr`; 8..32.
- `RESET_PC`, 0: PC value loaded on reset; word-aligned.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: 1 = write (sw); 0 = read.
- `mem_addr`  out  ADDR_W: byte address.
- `mem_wdata`  out  32: store data.
- `mem_rdata`  in  32: read data; valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1: access completes at the edge where `mem_req`=1 and `mem_ready`=1.
- `pc`  out  ADDR_W: current PC register.
- `retired`  out  32: count of completed instructions; wraps at 2^32.
- `halted`  out  1: core is stopped on an illegal instruction.

## Operation
- Internal state: PC, IR, A, B, MDR, ALUOut, 32×32 register file. `$0` reads 0; writes to `$0` are dropped.
- Supported instructions:
  - R-type (op 0x00) funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
  - Any other op or funct is illegal and sends the FSM to HALT.
- Arithmetic wraps modulo 2^32. No overflow trap. Immediates are sign-extended from 16 bits.
- States and transitions:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ready: IR←rdata, PC←PC+4, go to DECODE. Otherwise stay.
  - DECODE: A←rf[rs], B←rf[rt], ALUOut←PC+(sext(imm)<<2). Dispatch on opcode.
  - MEMADR: ALUOut←A+sext(imm). Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: read request at ALUOut. On ready: MDR←rdata, go to MEMWB.
  - MEMWB: rf[rt]←MDR, go to FETCH.
  - MEMWR: `mem_we`=1, `mem_wdata`=B. On ready, go to FETCH.
  - EXEC: ALUOut←A op B, go to ALUWB.
  - ALUWB: rf[rd]←ALUOut, go to FETCH.
  - ADDIEX: ALUOut←A+sext(imm), go to ADDIWB.
  - ADDIWB: rf[rt]←ALUOut, go to FETCH.
  - BRANCH: if A==B then PC←ALUOut. Go to FETCH.
  - JUMP: PC←{PC[ADDR_W-1:28], target26, 2'b00}, truncated to ADDR_W when ADDR_W<28. Go to FETCH.
  - HALT: `halted`=1, `mem_req`=0. Leaves only on reset.
- `retired` increments by 1 on the final-state edge of each legal instruction. It does not increment for the halting instruction.
- Address low bits are passed through unchanged; the core does no misalignment check.
- `mem_addr` is ADDR_W bits. Effective addresses are truncated to ADDR_W.

## Timing
- Reset state: FETCH, PC=RESET_PC, all registers 0, `retired`=0, `halted`=0, `mem_req`=0 for one cycle after reset release.
- FETCH asserts `mem_req` starting the first cycle after `rst_n` goes high.
- Cycles per instruction with a zero-wait memory (`mem_ready` tied 1):
  - R-type: 4
  - lw: 5
  - sw: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each cycle with `mem_ready`=0 during FETCH, MEMRD or MEMWR adds one cycle.
- Handshake hold rule: while `mem_req`=1 and `mem_ready`=0, the core holds `mem_addr`, `mem_we` and `mem_wdata` stable.
- `mem_req` is combinational from the state. It drops the cycle after completion unless the next state also requests.
- Reset mid-transaction: state aborts at that edge and `mem_req`=0 in the next cycle. The memory must tolerate the abandoned request.
- `mem_ready` is ignored while `mem_req`=0.
- A register written in a WB state is readable in the next instruction's DECODE. No forwarding is needed.

## Test plan
- Reset, RESET_PC=0x40, ready tied 1, memory all 0 (`sll`, i.e. funct 0): `mem_addr`=0x40 in the first active cycle, then HALT. `halted`=1, `retired`=0, PC=0x44.
- Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0); lw $4,0x10($0): mem[0x10]=12, $4=12, `retired`=5 after 21 cycles.
- beq $0,$0,+2 at 0x00 → next fetch at 0x0C, 3 cycles. beq with unequal operands → next fetch at 0x04.
- slt with $1=−1, $2=1 → result 1. sub 0−1 → 0xFFFFFFFF.
- `mem_ready` low for 3 cycles during a lw read: address and `mem_we` stay stable. The lw takes 8 cycles. Loaded value is correct.
- `rst_n` low during MEMWR wait: no write completes, PC returns to RESET_PC, `retired`=0. j with ADDR_W=16 truncates the target to 16 bits.
